// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding several byte streams into one UART TX FIFO
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   enable_i                        allows new grants (never cuts a running burst)
//   flush_i                         aborts the current grant
//   req_valid_i/req_data_i/req_last_i  per-requester byte stream, requester k on data[8k+7:8k]
//   req_ready_o                     per-requester byte accepted this cycle
//   tx_d_o, tx_d_valid_o, tx_full_i FIFO enqueue side and its full backpressure
//   grant_o, busy_o                 one-hot current owner, grant held
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 flush_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_d_o,
  output logic                 tx_d_valid_o,
  input  logic                 tx_full_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [8:0] MB = 9'(MAX_BURST);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0] idx_q, idx_d, last_ptr, ptr_d, win_idx, cand;
  logic [8:0] cnt_q, cnt_d;
  logic found, active, xfer;
  // outputs are held quiet while reset is asserted so no byte is taken from a requester
  assign active = state_q == BURST && rst_n;
  assign xfer = active && !flush_i && req_valid_i[idx_q] && !tx_full_i;
  assign tx_d_valid_o = xfer;
  assign req_ready_o = xfer ? grant_q : '0;
  assign tx_d_o = active ? req_data_i[{idx_q, 3'b000} +: 8] : 8'h00;
  assign grant_o = grant_q;
  assign busy_o = state_q == BURST;
  // search starts one past the last released owner and wraps
  always_comb begin
    win_idx = '0;
    found = 1'b0;
    cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PW'((int'(last_ptr) + i) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win_idx = cand;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    ptr_d = last_ptr;
    if (flush_i) begin
      state_d = IDLE;
      grant_d = '0;
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      if (enable_i && found) begin
        state_d = BURST;
        grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
        idx_d = win_idx;
        cnt_d = '0;
      end
    end else if (xfer) begin
      cnt_d = cnt_q + 9'd1;
      if (req_last_i[idx_q] || cnt_q + 9'd1 == MB) begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d = '0;
        ptr_d = idx_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      last_ptr <= PW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      last_ptr <= ptr_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_i = 1'b0;
  logic flush_i = 1'b0;
  logic tx_full_i = 1'b0;
  logic [3:0] req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [31:0] req_data_i;
  logic [7:0] tx_d_o;
  logic tx_d_valid_o, busy_o;
  int checks = 0;
  int errors = 0;
  int pos[4];
  int plen = 0;
  int n = 0;
  logic [3:0] mask = 4'h0;
  logic [3:0] s_grant, s_ready;
  logic [7:0] s_txd;
  logic s_txv;
  localparam logic [3:0] EG [10] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h2};
  localparam logic [7:0] ED [10] = '{8'h00, 8'h40, 8'h41, 8'h42, 8'h00, 8'hC0, 8'hC1, 8'hC2, 8'h00, 8'h43};
  always #5 clk = ~clk;
  uart_tx_arbiter dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .tx_d_o(tx_d_o), .tx_d_valid_o(tx_d_valid_o),
    .tx_full_i(tx_full_i), .grant_o(grant_o), .busy_o(busy_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      req_valid_i[k] = mask[k];
      req_data_i[8*k +: 8] = 8'(k * 64 + pos[k]);
      req_last_i[k] = (plen != 0) ? (pos[k] % plen == plen - 1) : 1'b0;
    end
  endtask
  task automatic cyc();
    drive();
    #1;
    s_grant = grant_o;
    s_ready = req_ready_o;
    s_txd = tx_d_o;
    s_txv = tx_d_valid_o;
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (s_ready[k]) pos[k]++;
    #1;
  endtask
  initial begin
    req_valid_i = '0;
    req_data_i = '0;
    req_last_i = '0;
    foreach (pos[k]) pos[k] = 0;
    enable_i = 1'b1;
    mask = 4'hF;
    repeat (3) cyc();
    chk("rst_grant", s_grant, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_txv", s_txv, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_txd", s_txd, 0);
    foreach (pos[k]) pos[k] = 0;
    mask = 4'b1010;
    plen = 3;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("rr_grant", s_grant, EG[i]);
      chk("rr_ready", s_ready, EG[i]);
      chk("rr_txd", s_txd, ED[i]);
      chk("rr_txv", s_txv, EG[i] != 0);
    end
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("flush_txv", s_txv, 0);
    chk("flush_ready", s_ready, 0);
    chk("flush_grant", grant_o, 0);
    chk("flush_busy", busy_o, 0);
    mask = 4'b0001;
    plen = 0;
    pos[0] = 0;
    n = 0;
    for (int i = 0; i < 43; i++) begin
      cyc();
      chk("burst_grant", s_grant, (i % 17 == 0) ? 4'h0 : 4'h1);
      chk("burst_txv", s_txv, i % 17 != 0);
      if (s_txv) begin
        chk("burst_data", s_txd, n);
        n++;
      end
    end
    chk("burst_total", n, 40);
    mask = 4'b0000;
    cyc();
    chk("hold_grant", s_grant, 4'h1);
    chk("hold_txv", s_txv, 0);
    chk("hold_busy", busy_o, 1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    mask = 4'b0100;
    plen = 5;
    pos[2] = 0;
    cyc();
    chk("full_idle", s_grant, 0);
    cyc();
    chk("full_g", s_grant, 4'h4);
    chk("full_b0", s_txd, 8'h80);
    cyc();
    chk("full_b1", s_txd, 8'h81);
    tx_full_i = 1'b1;
    repeat (5) begin
      cyc();
      chk("full_txv", s_txv, 0);
      chk("full_ready", s_ready, 0);
      chk("full_hold", s_grant, 4'h4);
    end
    tx_full_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("full_resume", s_txd, 8'h82 + i);
      chk("full_rtxv", s_txv, 1);
    end
    chk("full_rel", grant_o, 0);
    chk("full_rel_busy", busy_o, 0);
    mask = 4'b1100;
    pos[3] = 0;
    cyc();
    chk("fl_idle", s_grant, 0);
    cyc();
    chk("fl_g3", s_grant, 4'h8);
    chk("fl_b0", s_txd, 8'hC0);
    cyc();
    chk("fl_b1", s_txd, 8'hC1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("fl_txv", s_txv, 0);
    chk("fl_ready", s_ready, 0);
    chk("fl_clear", grant_o, 0);
    cyc();
    chk("fl_idle2", s_grant, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("fl_regrant", s_grant, 4'h8);
      chk("fl_resume", s_txd, 8'hC2 + i);
    end
    cyc();
    chk("fl_gap", s_grant, 0);
    cyc();
    chk("fl_next", s_grant, 4'h4);
    chk("fl_next_d", s_txd, 8'h85);
    mask = 4'b0000;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    enable_i = 1'b0;
    mask = 4'b1111;
    plen = 3;
    pos[0] = 0;
    repeat (4) begin
      cyc();
      chk("en_off", s_grant, 0);
      chk("en_busy", busy_o, 0);
    end
    enable_i = 1'b1;
    cyc();
    chk("en_idle", s_grant, 0);
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("en_drop", s_grant, 4'h1);
      chk("en_data", s_txd, i);
    end
    repeat (3) begin
      cyc();
      chk("en_hold", s_grant, 0);
      chk("en_htxv", s_txv, 0);
    end
    enable_i = 1'b1;
    mask = 4'b0100;
    plen = 0;
    pos[2] = 0;
    repeat (4) cyc();
    chk("rb_g", s_grant, 4'h4);
    chk("rb_b3", s_txd, 8'h82);
    rst_n = 1'b0;
    cyc();
    chk("rb_txv", s_txv, 0);
    chk("rb_ready", s_ready, 0);
    chk("rb_txd", s_txd, 0);
    chk("rb_grant", grant_o, 0);
    chk("rb_busy", busy_o, 0);
    rst_n = 1'b1;
    mask = 4'b0101;
    cyc();
    chk("rb_idle", s_grant, 0);
    cyc();
    chk("rb_win0", s_grant, 4'h1);
    chk("rb_kept", pos[2], 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
